// File: rtl/odd_result_pipe.sv
// odd_result_pipe: ages oddpipe results through NUM_STAGES registers, forwards ready
// values to ra/rb/rc, flags not-ready RAW matches and writes back from the last stage.
module odd_result_pipe #(
  parameter int NUM_STAGES = 7,
  parameter int MIN_LAT = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [142:0] op_packet,
  input  logic         flush,
  input  logic [6:0]   qa_address,
  input  logic [6:0]   qb_address,
  input  logic [6:0]   qc_address,
  output logic         qa_hit,
  output logic         qb_hit,
  output logic         qc_hit,
  output logic [127:0] qa_data,
  output logic [127:0] qb_data,
  output logic [127:0] qc_data,
  output logic         stall_hazard,
  output logic         wb_en,
  output logic [6:0]   wb_address,
  output logic [127:0] wb_data
);
  // packet bit 0 is the MSB: data, rt, write enable, unit id, latency
  logic [127:0] s_data [1:NUM_STAGES];
  logic [6:0]   s_rt   [1:NUM_STAGES];
  logic         s_we   [1:NUM_STAGES];
  logic [3:0]   s_leff [1:NUM_STAGES];
  logic [3:0]   in_lat, in_leff;
  logic [6:0]   q_addr [0:2];
  logic         f_hit  [0:2];
  logic         f_haz  [0:2];
  logic [127:0] f_data [0:2];
  logic         unused_unit;

  assign unused_unit = ^op_packet[6:4];
  assign in_lat = op_packet[3:0];
  assign in_leff = (in_lat < 4'(MIN_LAT)) ? 4'(MIN_LAT) :
                   (in_lat > 4'(NUM_STAGES)) ? 4'(NUM_STAGES) : in_lat;

  // flush kills only the two packets younger than the mispredicted branch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        s_data[k] <= '0;
        s_rt[k]   <= '0;
        s_we[k]   <= 1'b0;
        s_leff[k] <= '0;
      end
    end else begin
      s_data[1] <= op_packet[142:15];
      s_rt[1]   <= op_packet[14:8];
      s_we[1]   <= op_packet[7] & ~flush;
      s_leff[1] <= in_leff;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        s_data[k] <= s_data[k-1];
        s_rt[k]   <= s_rt[k-1];
        s_we[k]   <= s_we[k-1] & ~(flush && k == 2);
        s_leff[k] <= s_leff[k-1];
      end
    end
  end

  assign q_addr[0] = qa_address;
  assign q_addr[1] = qb_address;
  assign q_addr[2] = qc_address;

  // scan oldest to youngest so the youngest live match wins, ready or not
  always_comb begin
    for (int q = 0; q < 3; q++) begin
      f_hit[q]  = 1'b0;
      f_haz[q]  = 1'b0;
      f_data[q] = '0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (s_we[k] && s_rt[k] == q_addr[q]) begin
          f_hit[q]  = k >= int'(s_leff[k]);
          f_haz[q]  = k < int'(s_leff[k]);
          f_data[q] = (k >= int'(s_leff[k])) ? s_data[k] : '0;
        end
      end
    end
  end

  assign qa_hit = f_hit[0];
  assign qb_hit = f_hit[1];
  assign qc_hit = f_hit[2];
  assign qa_data = f_data[0];
  assign qb_data = f_data[1];
  assign qc_data = f_data[2];
  assign stall_hazard = f_haz[0] | f_haz[1] | f_haz[2];
  assign wb_en = s_we[NUM_STAGES];
  assign wb_address = s_rt[NUM_STAGES];
  assign wb_data = s_data[NUM_STAGES];
endmodule

// File: tb/tb_odd_result_pipe.sv
// tb_odd_result_pipe: scenario tasks with a writeback scoreboard for odd_result_pipe.
module tb_odd_result_pipe;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [142:0] op_packet = '0;
  logic         flush = 1'b0;
  logic [6:0]   qa_address = 7'd127, qb_address = 7'd127, qc_address = 7'd127;
  logic         qa_hit, qb_hit, qc_hit, stall_hazard, wb_en;
  logic [127:0] qa_data, qb_data, qc_data, wb_data;
  logic [6:0]   wb_address;

  typedef struct {
    int           due;
    logic [6:0]   rt;
    logic [127:0] data;
  } wb_t;

  wb_t sb[$];
  int  now = 0;
  int  errors = 0;
  int  checks = 0;

  odd_result_pipe dut (
    .clock(clock), .reset(reset), .op_packet(op_packet), .flush(flush),
    .qa_address(qa_address), .qb_address(qb_address), .qc_address(qc_address),
    .qa_hit(qa_hit), .qb_hit(qb_hit), .qc_hit(qc_hit),
    .qa_data(qa_data), .qb_data(qb_data), .qc_data(qc_data),
    .stall_hazard(stall_hazard), .wb_en(wb_en), .wb_address(wb_address), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  // drive one packet for one edge; every edge also checks the writeback port
  task automatic step(input logic [127:0] d, input logic [6:0] rt, input logic we,
                      input logic [3:0] l, input logic f, input bit wb);
    op_packet = {d, rt, we, 3'd1, l};
    flush = f;
    if (wb) sb.push_back('{now + 7, rt, d});
    @(posedge clock);
    #1;
    now++;
    op_packet = '0;
    flush = 1'b0;
    checks++;
    if (sb.size() > 0 && sb[0].due == now) begin
      if (wb_en !== 1'b1 || wb_address !== sb[0].rt || wb_data !== sb[0].data) begin
        errors++;
        $display("FAIL wb cycle %0d: got en=%b addr=%0d data=%0d, want en=1 addr=%0d data=%0d",
                 now, wb_en, wb_address, wb_data, sb[0].rt, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (wb_en !== 1'b0) begin
      errors++;
      $display("FAIL wb_idle cycle %0d: got en=%b addr=%0d, want en=0", now, wb_en, wb_address);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if ({wb_en, wb_address, wb_data, qa_hit, qb_hit, qc_hit, stall_hazard} !== '0) begin
      errors++;
      $display("FAIL reset_initial: got en=%b hit=%b%b%b haz=%b, want all 0",
               wb_en, qa_hit, qb_hit, qc_hit, stall_hazard);
    end
    #2 reset = 1'b1;
    idle(2);
    qa_address = 7'd10;
    qb_address = 7'd16;
    for (int i = 0; i < 7; i++) step(128'(1000 + i), 7'(10 + i), 1'b1, 4'd2, 1'b0, 1'b1);
    checks++;
    if (qa_hit !== 1'b1 || qa_data !== 128'd1000 || stall_hazard !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: got qa_hit=%b qa_data=%0d haz=%b, want 1 1000 1",
               qa_hit, qa_data, stall_hazard);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({wb_en, wb_address, wb_data, qa_hit, qa_data, qb_hit, qb_data, stall_hazard} !== '0) begin
      errors++;
      $display("FAIL reset_async: got en=%b addr=%0d qa_hit=%b qa_data=%0d haz=%b, want all 0",
               wb_en, wb_address, qa_hit, qa_data, stall_hazard);
    end
    sb.delete();
    #2 reset = 1'b1;
    idle(9);
    qa_address = 7'd127;
    qb_address = 7'd127;
  endtask

  task automatic test_latency_forward();
    qa_address = 7'd5;
    step(128'd20, 7'd5, 1'b1, 4'd4, 1'b0, 1'b1);
    for (int s = 1; s <= 7; s++) begin
      checks++;
      if (s <= 3 && (stall_hazard !== 1'b1 || qa_hit !== 1'b0 || qa_data !== '0)) begin
        errors++;
        $display("FAIL fwd_hazard stage %0d: got haz=%b hit=%b data=%0d, want 1 0 0",
                 s, stall_hazard, qa_hit, qa_data);
      end else if (s > 3 && (stall_hazard !== 1'b0 || qa_hit !== 1'b1 || qa_data !== 128'd20)) begin
        errors++;
        $display("FAIL fwd_ready stage %0d: got haz=%b hit=%b data=%0d, want 0 1 20",
                 s, stall_hazard, qa_hit, qa_data);
      end
      if (s < 7) idle(1);
    end
    idle(3);
    qa_address = 7'd127;
  endtask

  task automatic test_youngest();
    qb_address = 7'd9;
    step(128'd111, 7'd9, 1'b1, 4'd2, 1'b0, 1'b1);
    step(128'd222, 7'd9, 1'b1, 4'd6, 1'b0, 1'b1);
    checks++;
    if (stall_hazard !== 1'b1 || qb_hit !== 1'b0) begin
      errors++;
      $display("FAIL youngest_stage1: got haz=%b qb_hit=%b, want 1 0", stall_hazard, qb_hit);
    end
    idle(4);
    checks++;
    if (stall_hazard !== 1'b1 || qb_hit !== 1'b0 || qb_data !== '0) begin
      errors++;
      $display("FAIL youngest_stage5: got haz=%b qb_hit=%b qb_data=%0d, want 1 0 0",
               stall_hazard, qb_hit, qb_data);
    end
    idle(1);
    checks++;
    if (qb_hit !== 1'b1 || qb_data !== 128'd222 || stall_hazard !== 1'b0) begin
      errors++;
      $display("FAIL youngest_stage6: got qb_hit=%b qb_data=%0d haz=%b, want 1 222 0",
               qb_hit, qb_data, stall_hazard);
    end
    idle(3);
    qb_address = 7'd127;
  endtask

  task automatic test_flush();
    qa_address = 7'd3;
    qb_address = 7'd4;
    qc_address = 7'd2;
    step(128'd77, 7'd2, 1'b1, 4'd2, 1'b0, 1'b1);
    step(128'd33, 7'd3, 1'b1, 4'd2, 1'b0, 1'b0);
    step(128'd44, 7'd4, 1'b1, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (qa_hit !== 1'b0 || qb_hit !== 1'b0 || stall_hazard !== 1'b0) begin
        errors++;
        $display("FAIL flush_kill step %0d: got qa_hit=%b qb_hit=%b haz=%b, want 0 0 0",
                 i, qa_hit, qb_hit, stall_hazard);
      end
      if (i == 0) begin
        checks++;
        if (qc_hit !== 1'b1 || qc_data !== 128'd77) begin
          errors++;
          $display("FAIL flush_older: got qc_hit=%b qc_data=%0d, want 1 77", qc_hit, qc_data);
        end
      end
      idle(1);
    end
    qa_address = 7'd127;
    qb_address = 7'd127;
    qc_address = 7'd127;
  endtask

  task automatic test_clamp();
    qc_address = 7'd20;
    step(128'h55, 7'd20, 1'b1, 4'd0, 1'b0, 1'b1);
    checks++;
    if (qc_hit !== 1'b0 || stall_hazard !== 1'b1) begin
      errors++;
      $display("FAIL clamp_low_s1: got qc_hit=%b haz=%b, want 0 1", qc_hit, stall_hazard);
    end
    idle(1);
    checks++;
    if (qc_hit !== 1'b1 || qc_data !== 128'h55) begin
      errors++;
      $display("FAIL clamp_low_s2: got qc_hit=%b qc_data=%0h, want 1 55", qc_hit, qc_data);
    end
    idle(6);
    qc_address = 7'd0;
    step(128'h99, 7'd0, 1'b1, 4'd15, 1'b0, 1'b1);
    for (int s = 1; s <= 7; s++) begin
      checks++;
      if (qc_hit !== (s == 7) || stall_hazard !== (s != 7)) begin
        errors++;
        $display("FAIL clamp_high stage %0d: got qc_hit=%b haz=%b, want %b %b",
                 s, qc_hit, stall_hazard, s == 7, s != 7);
      end
      if (s < 7) idle(1);
    end
    idle(2);
    qc_address = 7'd127;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic we;
      we = 1'($urandom_range(0, 3) != 0);
      step({$urandom, $urandom, $urandom, $urandom}, 7'($urandom_range(0, 126)), we,
           4'($urandom_range(0, 15)), 1'b0, we);
    end
    idle(8);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending writebacks, want 0", sb.size());
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_latency_forward();
    test_youngest();
    test_flush();
    test_clamp();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/odd_result_pipe.md
Name: odd_result_pipe

Overview:
- Result staging and forwarding pipe directly downstream of oddpipe.
- Each cycle it takes the 143-bit oddpipe result packet (out_op) and ages it through NUM_STAGES registered stages.
- Exposes ready results to the register-fetch forwarding network for ra/rb/rc, and retires packets to the register file write port at a fixed depth.
- Flags RAW hazards on results that are still in flight but not yet ready.

Parameters:
- NUM_STAGES, 7, number of staging registers; writeback occurs from stage NUM_STAGES.
- MIN_LAT, 2, minimum unit latency; smaller latency fields are clamped up to this value.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_packet  in  143  oddpipe result packet (format below), sampled every cycle.
- flush  in  1  branch mispredict; kills the younger in-flight packets.
- qa_address, qb_address, qc_address  in  7 each  register-fetch source addresses for ra, rb, rc.
- qa_hit, qb_hit, qc_hit  out  1 each  a ready forwarded value exists for that source.
- qa_data, qb_data, qc_data  out  128 each  forwarded value; 0 when there is no hit.
- stall_hazard  out  1  some source matches an in-flight packet that is not yet ready.
- wb_en  out  1  register file write enable.
- wb_address  out  7  register file write address.
- wb_data  out  128  register file write data.

Behaviour:
- Packet format, bit 0 = MSB:
  - [0:127] result data
  - [128:134] rt address
  - [135] write enable
  - [136:138] unit id
  - [139:142] latency L
- Effective latency Leff = clamp(L, MIN_LAT, NUM_STAGES).
- Stage 1 registers op_packet on each rising edge. Stage k+1 registers stage k. There is no stall input; the pipe always advances.
- Stage k is live when its write enable is 1.
- Stage k is ready when it is live and k >= Leff.
- Writeback outputs are registered:
  - wb_en = stage NUM_STAGES write enable.
  - wb_address and wb_data come from the same stage.
  - Total latency from op_packet to wb_en is NUM_STAGES cycles.
- Each forwarding query (qa/qb/qc) is purely combinational over stages 1..NUM_STAGES. op_packet itself is not forwarded.
  - The candidate is the youngest live stage whose rt address equals the query address.
  - Youngest means the lowest k.
  - If that candidate is ready: hit=1 and data = its data.
  - If that candidate is live but not ready: hit=0, data=0, and it contributes to stall_hazard.
  - An older ready match never overrides a younger not-ready match.
- stall_hazard is the OR of the not-ready conditions of all three queries.
- Flush:
  - On a clock edge with flush=1, stage 1 captures op_packet with write enable forced to 0.
  - The packet already in stage 1 moves to stage 2 with write enable forced to 0.
  - Stages 2..NUM_STAGES-1 advance unchanged, since they are older than the branch.
- Stage NUM_STAGES write enable is never affected by flush in the same edge.
- Reset (active low, asynchronous):
  - All stage registers and wb_en, wb_address, wb_data clear to 0 immediately.
  - Consequently all hit outputs, all data outputs and stall_hazard read 0.
  - A reset asserted mid-operation discards every in-flight packet; no writeback occurs for them.
- Duplicate rt addresses in flight are legal. Youngest-wins applies to forwarding, and each packet still writes back in order.
- Address 0 is a normal register with no special case.
- A packet with write enable 0 travels through the pipe but is invisible to forwarding and to writeback.

Test Plan:
- Reset:
  - Stimulus: drive reset=0 with live packets in stages 1..7.
  - Required: all outputs read 0 immediately. After release, no wb_en for the discarded packets.
- Writeback latency:
  - Stimulus: at cycle 0 inject data=128'd20, rt=7'd5, wrt_en=1, L=4.
  - Required: wb_en=1, wb_address=5, wb_data=20 exactly 7 cycles later, and wb_en=0 before and after that cycle.
- Forward vs. hazard:
  - Stimulus: same packet as above, with qa_address=5.
  - Required: while the packet is in stages 1..3, stall_hazard=1 and qa_hit=0. In stages 4..7, qa_hit=1, qa_data=20, stall_hazard=0.
- Youngest wins:
  - Stimulus: rt=9 data=111 L=2, followed the next cycle by rt=9 data=222 L=6, with qb_address=9.
  - Required: one cycle after the second packet is injected, stall_hazard=1 even though the older packet is ready.
  - Required: once the second packet is in stage 6, qb_data=222.
- Flush:
  - Stimulus: inject P1 (rt=3); next cycle assert flush while injecting P2 (rt=4).
  - Required: neither P1 nor P2 is ever forwarded or written back. Packets injected earlier are still written back normally.
- Latency clamp:
  - Stimulus: L=0 with qc_address matching.
  - Required: ready from stage 2, i.e. qc_hit=1 beginning two edges after injection.
  - Stimulus: L=15 with qc_address matching.
  - Required: qc_hit only when the packet is in stage 7.
